// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice (two half adders) reused
// LSB-first over WIDTH cycles, with a start/busy/done handshake.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s0, c0, s1, c1;

  half_adder ha0 (.x(sa[0]), .y(sb[0]), .s(s0), .c(c0));
  half_adder ha1 (.x(s0),    .y(carry), .s(s1), .c(c1));

  // New sum bit enters at the MSB so the LSB-first result lands aligned
  // after WIDTH shifts; written this way so WIDTH=1 needs no special case.
  always_comb begin
    acc_next            = acc >> 1;
    acc_next[WIDTH-1]   = s1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= c0 | c1;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          // Counter holds at its last value instead of wrapping.
          if (cnt == CNT_LAST) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          sum   <= acc;
          cout  <= carry;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
